// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the machine-mode CSR/trap unit: CSR addresses, op encodings,
// mstatus bit positions and interrupt codes.
package csr_trap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_WRITE = 2'b00,
        CSR_OP_SET   = 2'b01,
        CSR_OP_CLEAR = 2'b10,
        CSR_OP_NONE  = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam int IRQ_CODE_EXT   = 11;
    localparam int IRQ_CODE_TIMER = 7;
    localparam int IRQ_CODE_SW    = 3;

    // Bit positions inside the compact 3-bit mip/mie storage.
    localparam int IRQ_EXT   = 2;
    localparam int IRQ_TIMER = 1;
    localparam int IRQ_SW    = 0;

    // CSRs written by trap entry; a same-cycle software write to these loses.
    function automatic logic is_trap_csr(input logic [11:0] a);
        return (a == CSR_MSTATUS) || (a == CSR_MEPC) || (a == CSR_MCAUSE) || (a == CSR_MTVAL);
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half software load; a load wins over the increment.
module csr_counter64 #(
    parameter int XLEN = 32,
    parameter bit EN   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            ld_lo_i,
    input  logic            ld_hi_i,
    input  logic [XLEN-1:0] ld_data_i,
    output logic [63:0]     cnt_o
);

    generate
        if (!EN) begin : g_off
            assign cnt_o = '0;
        end else begin : g_on
            logic [63:0] cnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (ld_lo_i || ld_hi_i) begin
                    if (XLEN == 32) begin
                        if (ld_lo_i) cnt_q[31:0]  <= ld_data_i[31:0];
                        if (ld_hi_i) cnt_q[63:32] <= ld_data_i[31:0];
                    end else if (ld_lo_i) begin
                        cnt_q <= 64'(ld_data_i);
                    end
                end else if (inc_i) begin
                    cnt_q <= cnt_q + 64'd1;
                end
            end

            assign cnt_o = cnt_q;
        end
    endgenerate

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with RMW ops, mcycle/minstret, interrupt priority,
// trap entry / mret sequencing and a registered PC redirect.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
    parameter bit              HAS_COUNTERS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_rd_addr,
    output logic [XLEN-1:0] csr_rd_data,
    input  logic            csr_wr_en,
    input  logic [11:0]     csr_wr_addr,
    input  logic [XLEN-1:0] csr_wr_data,
    input  logic [1:0]      csr_op,
    input  logic            instr_retire,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret_req,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    output logic            irq_pending,
    output logic [XLEN-1:0] irq_cause,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    logic            mstatus_mie_q, mstatus_mpie_q;
    logic [2:0]      mie_q, mip_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic            irq_pending_q, irq_pending_d;
    logic [XLEN-1:0] irq_cause_q, irq_cause_d;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [63:0]     mcycle, minstret;

    logic [XLEN-1:0] wr_old, wr_raw, wr_new, trap_base, trap_target;
    logic            wr_blocked, wr_apply;
    logic [2:0]      irq_en;

    function automatic logic [XLEN-1:0] csr_value(input logic [11:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        case (a)
            CSR_MSTATUS: begin
                v[12:11]          = 2'b11;
                v[MSTATUS_MPIE]   = mstatus_mpie_q;
                v[MSTATUS_MIE]    = mstatus_mie_q;
            end
            CSR_MIE: begin
                v[IRQ_CODE_EXT]   = mie_q[IRQ_EXT];
                v[IRQ_CODE_TIMER] = mie_q[IRQ_TIMER];
                v[IRQ_CODE_SW]    = mie_q[IRQ_SW];
            end
            CSR_MIP: begin
                v[IRQ_CODE_EXT]   = mip_q[IRQ_EXT];
                v[IRQ_CODE_TIMER] = mip_q[IRQ_TIMER];
                v[IRQ_CODE_SW]    = mip_q[IRQ_SW];
            end
            CSR_MTVEC:     v = mtvec_q;
            CSR_MSCRATCH:  v = mscratch_q;
            CSR_MEPC:      v = mepc_q;
            CSR_MCAUSE:    v = mcause_q;
            CSR_MTVAL:     v = mtval_q;
            CSR_MCYCLE:    v = mcycle[XLEN-1:0];
            CSR_MINSTRET:  v = minstret[XLEN-1:0];
            CSR_MCYCLEH:   v = (XLEN == 32) ? XLEN'(mcycle[63:32]) : '0;
            CSR_MINSTRETH: v = (XLEN == 32) ? XLEN'(minstret[63:32]) : '0;
            default:       v = '0;
        endcase
        return v;
    endfunction

    // Value the register will actually hold after a write of d; also what the bypass returns.
    function automatic logic [XLEN-1:0] csr_legal(input logic [11:0] a, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] v;
        v = '0;
        case (a)
            CSR_MSTATUS: begin
                v[12:11]          = 2'b11;
                v[MSTATUS_MPIE]   = d[MSTATUS_MPIE];
                v[MSTATUS_MIE]    = d[MSTATUS_MIE];
            end
            CSR_MIE: begin
                v[IRQ_CODE_EXT]   = d[IRQ_CODE_EXT];
                v[IRQ_CODE_TIMER] = d[IRQ_CODE_TIMER];
                v[IRQ_CODE_SW]    = d[IRQ_CODE_SW];
            end
            CSR_MTVEC, CSR_MSCRATCH, CSR_MCAUSE, CSR_MTVAL: v = d;
            CSR_MEPC:                    v = {d[XLEN-1:2], 2'b00};
            CSR_MIP:                     v = csr_value(CSR_MIP);
            CSR_MCYCLE, CSR_MINSTRET:    v = HAS_COUNTERS ? d : '0;
            CSR_MCYCLEH, CSR_MINSTRETH:  v = (HAS_COUNTERS && XLEN == 32) ? d : '0;
            default:                     v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        wr_old = csr_value(csr_wr_addr);
        case (csr_op_e'(csr_op))
            CSR_OP_WRITE: wr_raw = csr_wr_data;
            CSR_OP_SET:   wr_raw = wr_old | csr_wr_data;
            CSR_OP_CLEAR: wr_raw = wr_old & ~csr_wr_data;
            default:      wr_raw = wr_old;
        endcase
        wr_new = csr_legal(csr_wr_addr, wr_raw);
    end

    // A software write survives a same-cycle trap/mret only if that event leaves its CSR alone.
    assign wr_blocked = trap_req ? is_trap_csr(csr_wr_addr)
                                 : (mret_req && (csr_wr_addr == CSR_MSTATUS));
    assign wr_apply   = csr_wr_en && (csr_op != CSR_OP_NONE) && !wr_blocked;

    assign csr_rd_data = rst ? '0
                       : (csr_wr_en && (csr_rd_addr == csr_wr_addr)) ? wr_new
                       : csr_value(csr_rd_addr);

    assign trap_base   = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_target = ((mtvec_q[1:0] == 2'b01) && trap_cause[XLEN-1])
                       ? trap_base + {trap_cause[XLEN-3:0], 2'b00}
                       : trap_base;

    assign irq_en = mip_q & mie_q;

    always_comb begin
        irq_pending_d = mstatus_mie_q & (|irq_en);
        irq_cause_d   = '0;
        if (irq_pending_d) begin
            irq_cause_d[XLEN-1] = 1'b1;
            if (irq_en[IRQ_EXT])     irq_cause_d[4:0] = 5'(IRQ_CODE_EXT);
            else if (irq_en[IRQ_SW]) irq_cause_d[4:0] = 5'(IRQ_CODE_SW);
            else                     irq_cause_d[4:0] = 5'(IRQ_CODE_TIMER);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q    <= 1'b0;
            mstatus_mpie_q   <= 1'b0;
            mie_q            <= '0;
            mip_q            <= '0;
            mtvec_q          <= MTVEC_RESET;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            irq_pending_q    <= 1'b0;
            irq_cause_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mip_q[IRQ_EXT]   <= irq_ext;
            mip_q[IRQ_TIMER] <= irq_timer;
            mip_q[IRQ_SW]    <= irq_sw;
            irq_pending_q    <= irq_pending_d;
            irq_cause_q      <= irq_cause_d;

            redirect_valid_q <= trap_req | mret_req;
            if (trap_req)      redirect_pc_q <= trap_target;
            else if (mret_req) redirect_pc_q <= mepc_q;

            if (wr_apply) begin
                case (csr_wr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie_q  <= wr_new[MSTATUS_MIE];
                        mstatus_mpie_q <= wr_new[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q <= {wr_new[IRQ_CODE_EXT], wr_new[IRQ_CODE_TIMER], wr_new[IRQ_CODE_SW]};
                    CSR_MTVEC:    mtvec_q    <= wr_new;
                    CSR_MSCRATCH: mscratch_q <= wr_new;
                    CSR_MEPC:     mepc_q     <= wr_new;
                    CSR_MCAUSE:   mcause_q   <= wr_new;
                    CSR_MTVAL:    mtval_q    <= wr_new;
                    default: ;
                endcase
            end

            if (trap_req) begin
                mepc_q         <= {trap_pc[XLEN-1:2], 2'b00};
                mcause_q       <= trap_cause;
                mtval_q        <= trap_val;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (mret_req) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end
        end
    end

    csr_counter64 #(.XLEN(XLEN), .EN(HAS_COUNTERS)) u_mcycle (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (1'b1),
        .ld_lo_i   (wr_apply && (csr_wr_addr == CSR_MCYCLE)),
        .ld_hi_i   (wr_apply && (XLEN == 32) && (csr_wr_addr == CSR_MCYCLEH)),
        .ld_data_i (wr_new),
        .cnt_o     (mcycle)
    );

    csr_counter64 #(.XLEN(XLEN), .EN(HAS_COUNTERS)) u_minstret (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (instr_retire),
        .ld_lo_i   (wr_apply && (csr_wr_addr == CSR_MINSTRET)),
        .ld_hi_i   (wr_apply && (XLEN == 32) && (csr_wr_addr == CSR_MINSTRETH)),
        .ld_data_i (wr_new),
        .cnt_o     (minstret)
    );

    assign irq_pending    = irq_pending_q;
    assign irq_cause      = irq_cause_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural CSR model.
module tb_csr_trap_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

    localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342;
    localparam logic [11:0] A_MTVAL = 12'h343, A_MIP = 12'h344;
    localparam logic [11:0] A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_rd_addr, csr_wr_addr;
    logic [31:0] csr_rd_data, csr_wr_data;
    logic        csr_wr_en;
    logic [1:0]  csr_op;
    logic        instr_retire, trap_req, mret_req;
    logic [31:0] trap_cause, trap_pc, trap_val;
    logic        irq_ext, irq_timer, irq_sw;
    logic        irq_pending, redirect_valid;
    logic [31:0] irq_cause, redirect_pc;

    always #5 clk = ~clk;

    csr_trap_unit #(.XLEN(32), .MTVEC_RESET(MTVEC_RST), .HAS_COUNTERS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
        .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data), .csr_op(csr_op),
        .instr_retire(instr_retire),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
        .mret_req(mret_req),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
        .irq_pending(irq_pending), .irq_cause(irq_cause),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: architectural read values of each CSR.
    logic [31:0] m_ms, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
    logic [63:0] m_cyc, m_ins;
    logic        m_rv, m_pend;
    logic [31:0] m_rpc, m_cause;

    logic [31:0] rd_seen, rpc_seen, cause_seen;
    logic        rv_seen, pend_seen;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            A_MSTATUS:   return m_ms;
            A_MIE:       return m_mie;
            A_MTVEC:     return m_mtvec;
            A_MSCRATCH:  return m_mscratch;
            A_MEPC:      return m_mepc;
            A_MCAUSE:    return m_mcause;
            A_MTVAL:     return m_mtval;
            A_MIP:       return m_mip;
            A_MCYCLE:    return m_cyc[31:0];
            A_MINSTRET:  return m_ins[31:0];
            A_MCYCLEH:   return m_cyc[63:32];
            A_MINSTRETH: return m_ins[63:32];
            default:     return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_legal(input logic [11:0] a, input logic [31:0] v);
        case (a)
            A_MSTATUS: return (v & 32'h88) | 32'h1800;
            A_MIE:     return v & 32'h888;
            A_MEPC:    return v & ~32'h3;
            A_MIP:     return m_mip;
            A_MTVEC, A_MSCRATCH, A_MCAUSE, A_MTVAL,
            A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH: return v;
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_newval();
        logic [31:0] old;
        old = m_read(csr_wr_addr);
        case (csr_op)
            2'b00:   return m_legal(csr_wr_addr, csr_wr_data);
            2'b01:   return m_legal(csr_wr_addr, old | csr_wr_data);
            2'b10:   return m_legal(csr_wr_addr, old & ~csr_wr_data);
            default: return old;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd();
        if (rst) return 32'h0;
        if (csr_wr_en && csr_rd_addr == csr_wr_addr) return m_newval();
        return m_read(csr_rd_addr);
    endfunction

    task automatic m_reset();
        m_ms = 32'h1800; m_mie = 0; m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_mip = 0; m_cyc = 0; m_ins = 0;
        m_rv = 0; m_rpc = 0; m_pend = 0; m_cause = 0;
    endtask

    task automatic model_step();
        logic        tk, mr, wr, p;
        logic [31:0] nv, ms0, en, c;
        logic [63:0] cyc_n, ins_n;
        if (rst) begin
            m_reset();
            return;
        end
        tk  = trap_req;
        mr  = mret_req && !trap_req;
        ms0 = m_ms;
        nv  = m_newval();
        wr  = csr_wr_en && csr_op != 2'b11;
        if (tk && (csr_wr_addr inside {A_MSTATUS, A_MEPC, A_MCAUSE, A_MTVAL})) wr = 0;
        if (mr && csr_wr_addr == A_MSTATUS) wr = 0;

        en = m_mip & m_mie;
        p  = ms0[3] && (en != 0);
        c  = !p ? 32'h0 : en[11] ? 32'h8000000B : en[3] ? 32'h80000003 : 32'h80000007;

        cyc_n = m_cyc + 1;
        ins_n = instr_retire ? m_ins + 1 : m_ins;

        m_rv = tk || mr;
        if (tk) begin
            if (m_mtvec[1:0] == 2'b01 && trap_cause[31])
                m_rpc = (m_mtvec & ~32'h3) + (trap_cause & 32'h7FFF_FFFF) * 4;
            else
                m_rpc = m_mtvec & ~32'h3;
        end else if (mr) begin
            m_rpc = m_mepc;
        end

        if (wr) begin
            case (csr_wr_addr)
                A_MSTATUS:   m_ms = nv;
                A_MIE:       m_mie = nv;
                A_MTVEC:     m_mtvec = nv;
                A_MSCRATCH:  m_mscratch = nv;
                A_MEPC:      m_mepc = nv;
                A_MCAUSE:    m_mcause = nv;
                A_MTVAL:     m_mtval = nv;
                A_MCYCLE:    cyc_n = {m_cyc[63:32], nv};
                A_MCYCLEH:   cyc_n = {nv, m_cyc[31:0]};
                A_MINSTRET:  ins_n = {m_ins[63:32], nv};
                A_MINSTRETH: ins_n = {nv, m_ins[31:0]};
                default: ;
            endcase
        end
        if (tk) begin
            m_mepc = trap_pc & ~32'h3;
            m_mcause = trap_cause;
            m_mtval = trap_val;
            m_ms = 32'h1800 | (ms0[3] ? 32'h80 : 32'h0);
        end else if (mr) begin
            m_ms = 32'h1880 | (ms0[7] ? 32'h8 : 32'h0);
        end
        m_mip = (irq_ext ? 32'h800 : 0) | (irq_timer ? 32'h80 : 0) | (irq_sw ? 32'h8 : 0);
        m_pend = p;
        m_cause = c;
        m_cyc = cyc_n;
        m_ins = ins_n;
    endtask

    // One clock: inputs are already driven just after the falling edge.
    task automatic tick();
        #1;
        rd_seen = csr_rd_data;
        chk("rd_data", {32'h0, rd_seen}, {32'h0, exp_rd()});
        model_step();
        @(posedge clk);
        @(negedge clk);
        rv_seen = redirect_valid; rpc_seen = redirect_pc;
        pend_seen = irq_pending;  cause_seen = irq_cause;
        chk("redirect_valid", {63'h0, rv_seen}, {63'h0, m_rv});
        if (m_rv) chk("redirect_pc", {32'h0, rpc_seen}, {32'h0, m_rpc});
        chk("irq_pending", {63'h0, pend_seen}, {63'h0, m_pend});
        chk("irq_cause", {32'h0, cause_seen}, {32'h0, m_cause});
    endtask

    task automatic idle_in();
        csr_wr_en = 0; csr_op = 2'b11; trap_req = 0; mret_req = 0; instr_retire = 0;
    endtask

    task automatic do_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        idle_in();
        csr_wr_en = 1; csr_wr_addr = a; csr_op = op; csr_wr_data = d; csr_rd_addr = a;
        tick();
    endtask

    task automatic do_rd(input logic [11:0] a);
        idle_in();
        csr_rd_addr = a;
        tick();
    endtask

    logic [11:0] addrs [14] = '{A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
                                A_MIP, A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH, 12'h301, 12'hFFF};

    initial begin
        m_reset();
        rst = 1; idle_in();
        csr_rd_addr = 0; csr_wr_addr = 0; csr_wr_data = 0;
        trap_cause = 0; trap_pc = 0; trap_val = 0;
        irq_ext = 0; irq_timer = 0; irq_sw = 0;
        @(negedge clk);

        // Reset and read-back of every address.
        tick(); tick();
        chk("rst_redirect_pc", {32'h0, rpc_seen}, 64'h0);
        rst = 0;
        for (int i = 0; i < 14; i++) do_rd(addrs[i]);
        do_rd(A_MSTATUS);  chk("rst_mstatus", {32'h0, rd_seen}, 64'h1800);
        do_rd(A_MTVEC);    chk("rst_mtvec", {32'h0, rd_seen}, {32'h0, MTVEC_RST});
        do_rd(A_MSCRATCH); chk("rst_mscratch", {32'h0, rd_seen}, 64'h0);

        // Read-modify-write ops with same-cycle bypass.
        do_wr(A_MSCRATCH, 2'b00, 32'hF0F0); chk("rmw_write", {32'h0, rd_seen}, 64'hF0F0);
        do_wr(A_MSCRATCH, 2'b01, 32'h000F); chk("rmw_set", {32'h0, rd_seen}, 64'hF0FF);
        do_wr(A_MSCRATCH, 2'b10, 32'h00F0); chk("rmw_clear", {32'h0, rd_seen}, 64'hF00F);
        do_rd(A_MSCRATCH);                  chk("rmw_read", {32'h0, rd_seen}, 64'hF00F);

        // Direct-mode trap.
        do_wr(A_MSTATUS, 2'b00, 32'h8);
        do_wr(A_MTVEC, 2'b00, 32'h1000);
        idle_in(); trap_req = 1; trap_cause = 2; trap_pc = 32'h203; trap_val = 32'hDEAD;
        tick();
        chk("trap_rv", {63'h0, rv_seen}, 64'h1);
        chk("trap_pc", {32'h0, rpc_seen}, 64'h1000);
        idle_in(); tick();
        chk("trap_rv_once", {63'h0, rv_seen}, 64'h0);
        do_rd(A_MEPC);    chk("trap_mepc", {32'h0, rd_seen}, 64'h200);
        do_rd(A_MCAUSE);  chk("trap_mcause", {32'h0, rd_seen}, 64'h2);
        do_rd(A_MTVAL);   chk("trap_mtval", {32'h0, rd_seen}, 64'hDEAD);
        do_rd(A_MSTATUS); chk("trap_mstatus", {32'h0, rd_seen}, 64'h1880);

        // Vectored external interrupt, trap, then mret.
        do_wr(A_MTVEC, 2'b00, 32'h1001);
        do_wr(A_MIE, 2'b00, 32'h800);
        do_wr(A_MSTATUS, 2'b01, 32'h8);
        idle_in(); irq_ext = 1; tick();
        chk("irq_lat1", {63'h0, pend_seen}, 64'h0);
        tick();
        chk("irq_pend", {63'h0, pend_seen}, 64'h1);
        chk("irq_cause_ext", {32'h0, cause_seen}, 64'h8000000B);
        idle_in(); trap_req = 1; trap_cause = 32'h8000000B; trap_pc = 32'h300; trap_val = 0;
        tick();
        chk("vec_pc", {32'h0, rpc_seen}, 64'h102C);
        idle_in(); mret_req = 1; tick();
        chk("mret_rv", {63'h0, rv_seen}, 64'h1);
        chk("mret_pc", {32'h0, rpc_seen}, 64'h300);
        irq_ext = 0;
        do_rd(A_MSTATUS); chk("mret_mie", {63'h0, rd_seen[3]}, 64'h1);

        // Counter wrap; the written value survives the write cycle.
        do_wr(A_MCYCLE, 2'b00, 32'hFFFF_FFFF);
        do_wr(A_MCYCLEH, 2'b00, 32'hFFFF_FFFF);
        do_rd(A_MCYCLE);  chk("cyc_hold", {32'h0, rd_seen}, 64'hFFFF_FFFF);
        do_rd(A_MCYCLE);  chk("cyc_wrap_lo", {32'h0, rd_seen}, 64'h0);
        do_rd(A_MCYCLEH); chk("cyc_wrap_hi", {32'h0, rd_seen}, 64'h0);

        // trap + mret + mepc write in one cycle: trap wins.
        idle_in(); csr_wr_en = 1; csr_wr_addr = A_MEPC; csr_op = 2'b00; csr_wr_data = 32'h1234;
        trap_req = 1; mret_req = 1; trap_cause = 5; trap_pc = 32'h404; trap_val = 0;
        tick();
        chk("conf_pc", {32'h0, rpc_seen}, 64'h1000);
        do_rd(A_MEPC);   chk("conf_mepc", {32'h0, rd_seen}, 64'h404);
        do_rd(A_MCAUSE); chk("conf_mcause", {32'h0, rd_seen}, 64'h5);

        // Reset in the trap cycle cancels the redirect.
        idle_in(); trap_req = 1; trap_cause = 1; trap_pc = 32'h80; rst = 1;
        tick();
        chk("rst_cancel", {63'h0, rv_seen}, 64'h0);
        rst = 0; idle_in();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            csr_wr_en    = ($urandom_range(0, 2) != 0);
            csr_wr_addr  = addrs[$urandom_range(0, 13)];
            csr_rd_addr  = ($urandom_range(0, 3) == 0) ? csr_wr_addr : addrs[$urandom_range(0, 13)];
            csr_op       = 2'($urandom_range(0, 3));
            csr_wr_data  = $urandom;
            if (csr_wr_addr == A_MSTATUS || csr_wr_addr == A_MIE) csr_wr_data = 32'($urandom_range(0, 15)) * 32'h88 | (csr_wr_data & 32'h800);
            instr_retire = 1'($urandom_range(0, 1));
            trap_req     = ($urandom_range(0, 15) == 0);
            mret_req     = ($urandom_range(0, 15) == 0);
            trap_cause   = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 15))};
            trap_pc      = $urandom;
            trap_val     = $urandom;
            if ($urandom_range(0, 3) == 0) irq_ext   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) irq_timer = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) irq_sw    = 1'($urandom_range(0, 1));
            rst          = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
